// File: rtl/load_align_unit_if.sv
// Load-path bundle: MEM-stage request, SRAM read port and writeback response.
interface load_align_unit_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic              mem_en;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [1:0]        resp_exc;
  logic [31:0]       resp_badvaddr;

  // Environment side: issues loads, models the SRAM, consumes responses.
  modport master (
    output req_valid, req_op, req_addr, mem_rdata, resp_ready,
    input  req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_exc, resp_badvaddr
  );

  // Load unit side.
  modport slave (
    input  req_valid, req_op, req_addr, mem_rdata, resp_ready,
    output req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_exc, resp_badvaddr
  );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts one load, issues an aligned SRAM read, waits
// RD_LAT cycles, then byte-selects and extends the returned lane.
//
// state | meaning
// IDLE  | no load in flight
// WAIT  | counting SRAM read latency
// DRAIN | flushed load still in flight in the SRAM; data will be dropped
// RESP  | holding a result for writeback
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  load_align_unit_if.slave  bus
);
  localparam int LANE_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, RESP} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        op_q, op_n;
  logic [LANE_W-1:0] lane_q, lane_n;
  logic              valid_q, valid_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [1:0]        exc_q, exc_n;
  logic [31:0]       bad_q, bad_n;

  logic              accept;
  logic              illegal;
  logic              misaligned;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] fmt;
  logic              sign_bit;
  int                nbits;

  // Decode legality and natural alignment of the incoming request.
  always_comb begin
    illegal = (bus.req_op == 3'b111) ||
              ((DATA_W == 32) && ((bus.req_op == 3'b101) || (bus.req_op == 3'b110)));
    case (bus.req_op[2:1])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
  end

  assign bus.req_ready = resetn && (state == IDLE) && !flush;
  assign accept        = bus.req_valid && bus.req_ready;
  // Faulting loads never touch the SRAM.
  assign bus.mem_en    = accept && !illegal && !misaligned;
  assign bus.mem_addr  = {bus.req_addr[31:LANE_W], {LANE_W{1'b0}}};

  // Select the addressed lane and extend it to the full result width.
  always_comb begin
    shifted = bus.mem_rdata >> {lane_q, 3'b000};
    case (op_q[2:1])
      2'b00:   begin nbits = 8;  sign_bit = shifted[7];  end
      2'b01:   begin nbits = 16; sign_bit = shifted[15]; end
      2'b10:   begin nbits = 32; sign_bit = shifted[31]; end
      default: begin nbits = 64; sign_bit = 1'b0;        end
    endcase
    fmt = shifted;
    // Even op codes are the signed variants; LD (110) keeps every bit.
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) fmt[i] = sign_bit & ~op_q[0];
    end
  end

  // Next-state and next-register values; defaults hold everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    lane_n  = lane_q;
    valid_n = valid_q;
    data_n  = data_q;
    exc_n   = exc_q;
    bad_n   = bad_q;
    case (state)
      IDLE: begin
        if (accept) begin
          bad_n = bus.req_addr;
          if (illegal || misaligned) begin
            state_n = RESP;
            valid_n = 1'b1;
            data_n  = '0;
            exc_n   = illegal ? 2'b10 : 2'b01;
          end else begin
            state_n = WAIT;
            cnt_n   = 3'(RD_LAT);
            op_n    = bus.req_op;
            lane_n  = bus.req_addr[LANE_W-1:0];
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (flush) begin
          // The count must still run out so the SRAM return is absorbed.
          state_n = (cnt == 3'd1) ? IDLE : DRAIN;
        end else if (cnt == 3'd1) begin
          state_n = RESP;
          valid_n = 1'b1;
          data_n  = fmt;
          exc_n   = 2'b00;
        end
      end
      DRAIN: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = IDLE;
      end
      RESP: begin
        if (flush || bus.resp_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          data_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      exc_q   <= 2'b00;
      bad_q   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_q    <= op_n;
      lane_q  <= lane_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      exc_q   <= exc_n;
      bad_q   <= bad_n;
    end
  end

  assign bus.resp_valid    = valid_q;
  assign bus.resp_data     = data_q;
  assign bus.resp_exc      = exc_q;
  assign bus.resp_badvaddr = bad_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit across three configurations:
// 32-bit/RD_LAT=1, 32-bit/RD_LAT=3 and 64-bit/RD_LAT=2, sharing one stimulus set.
module tb_load_align_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        resp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] rdata;
  int          sel;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  load_align_unit_if #(.DATA_W(32)) if_a ();
  load_align_unit_if #(.DATA_W(32)) if_c ();
  load_align_unit_if #(.DATA_W(64)) if_d ();

  assign if_a.req_valid = req_valid;
  assign if_a.req_op    = req_op;
  assign if_a.req_addr  = req_addr;
  assign if_a.mem_rdata = rdata[31:0];
  assign if_a.resp_ready = resp_ready;
  assign if_c.req_valid = req_valid;
  assign if_c.req_op    = req_op;
  assign if_c.req_addr  = req_addr;
  assign if_c.mem_rdata = rdata[31:0];
  assign if_c.resp_ready = resp_ready;
  assign if_d.req_valid = req_valid;
  assign if_d.req_op    = req_op;
  assign if_d.req_addr  = req_addr;
  assign if_d.mem_rdata = rdata;
  assign if_d.resp_ready = resp_ready;

  load_align_unit #(.DATA_W(32), .RD_LAT(1)) u_a (.clk(clk), .resetn(resetn), .flush(flush), .bus(if_a));
  load_align_unit #(.DATA_W(32), .RD_LAT(3)) u_c (.clk(clk), .resetn(resetn), .flush(flush), .bus(if_c));
  load_align_unit #(.DATA_W(64), .RD_LAT(2)) u_d (.clk(clk), .resetn(resetn), .flush(flush), .bus(if_d));

  logic        o_req_ready, o_mem_en, o_valid;
  logic [31:0] o_mem_addr, o_bad;
  logic [63:0] o_data;
  logic [1:0]  o_exc;

  // Observe the configuration currently under test.
  always_comb begin
    case (sel)
      0: begin
        o_req_ready = if_a.req_ready; o_mem_en = if_a.mem_en; o_valid = if_a.resp_valid;
        o_mem_addr = if_a.mem_addr; o_bad = if_a.resp_badvaddr;
        o_data = {32'h0, if_a.resp_data}; o_exc = if_a.resp_exc;
      end
      1: begin
        o_req_ready = if_c.req_ready; o_mem_en = if_c.mem_en; o_valid = if_c.resp_valid;
        o_mem_addr = if_c.mem_addr; o_bad = if_c.resp_badvaddr;
        o_data = {32'h0, if_c.resp_data}; o_exc = if_c.resp_exc;
      end
      default: begin
        o_req_ready = if_d.req_ready; o_mem_en = if_d.mem_en; o_valid = if_d.resp_valid;
        o_mem_addr = if_d.mem_addr; o_bad = if_d.resp_badvaddr;
        o_data = if_d.resp_data; o_exc = if_d.resp_exc;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    step();
    resetn = 1'b1;
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input int lat, input int hold, input logic [63:0] exp);
    logic [31:0] exp_ma;
    exp_ma = addr & ((sel == 2) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    #1;
    chk({tag, ".mem_en"}, 64'(o_mem_en), 64'h1);
    chk({tag, ".mem_addr"}, 64'(o_mem_addr), 64'(exp_ma));
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      #1;
      chk({tag, ".early_valid"}, 64'(o_valid), 64'h0);
      step();
    end
    #1;
    chk({tag, ".valid"}, 64'(o_valid), 64'h1);
    chk({tag, ".data"}, o_data, exp);
    chk({tag, ".exc"}, 64'(o_exc), 64'h0);
    chk({tag, ".badvaddr"}, 64'(o_bad), 64'(addr));
    chk({tag, ".ready_in_resp"}, 64'(o_req_ready), 64'h0);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      #1;
      chk({tag, ".hold_mem_en"}, 64'(o_mem_en), 64'h0);
      chk({tag, ".hold_ready"}, 64'(o_req_ready), 64'h0);
      step();
      chk({tag, ".hold_valid"}, 64'(o_valid), 64'h1);
      chk({tag, ".hold_data"}, o_data, exp);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    step();
    resp_ready = 1'b0;
    #1;
    chk({tag, ".post_valid"}, 64'(o_valid), 64'h0);
    chk({tag, ".post_data"}, o_data, 64'h0);
    chk({tag, ".post_ready"}, 64'(o_req_ready), 64'h1);
  endtask

  task automatic err_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] exc);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    #1;
    chk({tag, ".mem_en"}, 64'(o_mem_en), 64'h0);
    chk({tag, ".ready"}, 64'(o_req_ready), 64'h1);
    step();
    req_valid = 1'b0;
    #1;
    chk({tag, ".valid"}, 64'(o_valid), 64'h1);
    chk({tag, ".exc"}, 64'(o_exc), 64'(exc));
    chk({tag, ".badvaddr"}, 64'(o_bad), 64'(addr));
    chk({tag, ".data"}, o_data, 64'h0);
    resp_ready = 1'b1;
    #1;
    step();
    resp_ready = 1'b0;
    #1;
    chk({tag, ".post_valid"}, 64'(o_valid), 64'h0);
  endtask

  initial begin
    sel = 0;
    resetn = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h0; rdata = 64'h0;
    #1;
    chk("rst.req_ready", 64'(o_req_ready), 64'h0);
    chk("rst.mem_en", 64'(o_mem_en), 64'h0);
    step();
    chk("rst.valid", 64'(o_valid), 64'h0);
    chk("rst.data", o_data, 64'h0);
    chk("rst.exc", 64'(o_exc), 64'h0);
    chk("rst.badvaddr", 64'(o_bad), 64'h0);
    req_valid = 1'b0;
    resetn = 1'b1;
    #1;
    chk("rst.ready_after", 64'(o_req_ready), 64'h1);

    // 32-bit, RD_LAT=1: lane select and extension
    rdata = 64'h0000_0000_8011_2233;
    load_chk("lb_1003",  3'b000, 32'h1003, 1, 0, 64'hFFFF_FF80);
    load_chk("lbu_1003", 3'b001, 32'h1003, 1, 0, 64'h0000_0080);
    load_chk("lh_1002",  3'b010, 32'h1002, 1, 0, 64'hFFFF_8011);
    load_chk("lhu_1000", 3'b011, 32'h1000, 1, 0, 64'h0000_2233);
    load_chk("lb_1001",  3'b000, 32'h1001, 1, 0, 64'h0000_0022);
    load_chk("lw_1000",  3'b100, 32'h1000, 1, 0, 64'h8011_2233);
    err_chk("lh_1001",   3'b010, 32'h1001, 2'b01);
    err_chk("lw_1002",   3'b100, 32'h1002, 2'b01);
    err_chk("op7",       3'b111, 32'h1000, 2'b10);
    err_chk("op7_mis",   3'b111, 32'h1001, 2'b10);
    err_chk("lwu_32",    3'b101, 32'h1000, 2'b10);
    err_chk("ld_32",     3'b110, 32'h1000, 2'b10);

    // flush while holding a response, alone and together with resp_ready
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h1000;
      #1;
      step();
      req_valid = 1'b0;
      step();
      chk("fl_resp.valid", 64'(o_valid), 64'h1);
      flush = 1'b1; resp_ready = (k == 1);
      #1;
      chk("fl_resp.ready", 64'(o_req_ready), 64'h0);
      step();
      flush = 1'b0; resp_ready = 1'b0;
      #1;
      chk("fl_resp.post_valid", 64'(o_valid), 64'h0);
      chk("fl_resp.post_data", o_data, 64'h0);
      chk("fl_resp.post_ready", 64'(o_req_ready), 64'h1);
    end

    // flush in IDLE blocks the request
    flush = 1'b1; req_valid = 1'b1;
    #1;
    chk("fl_idle.ready", 64'(o_req_ready), 64'h0);
    chk("fl_idle.mem_en", 64'(o_mem_en), 64'h0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("fl_idle.valid", 64'(o_valid), 64'h0);

    // 32-bit, RD_LAT=3: backpressure
    sel = 1;
    do_reset();
    rdata = 64'h0000_0000_CAFE_F00D;
    load_chk("lw_bp", 3'b100, 32'h2000, 3, 4, 64'hCAFE_F00D);

    // flush one cycle after accept: the read drains, no response
    rdata = 64'h0000_0000_1111_1111;
    req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h2004;
    #1;
    chk("fl_wait.mem_en", 64'(o_mem_en), 64'h1);
    step();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl_wait.ready_c1", 64'(o_req_ready), 64'h0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_wait.valid_c2", 64'(o_valid), 64'h0);
    chk("fl_wait.ready_c2", 64'(o_req_ready), 64'h0);
    step();
    chk("fl_wait.valid_c3", 64'(o_valid), 64'h0);
    chk("fl_wait.ready_c3", 64'(o_req_ready), 64'h0);
    step();
    chk("fl_wait.valid_c4", 64'(o_valid), 64'h0);
    chk("fl_wait.ready_c4", 64'(o_req_ready), 64'h1);
    rdata = 64'h0000_0000_2222_2222;
    load_chk("lw_after_fl", 3'b100, 32'h2008, 3, 0, 64'h2222_2222);

    // reset during WAIT
    rdata = 64'h0000_0000_55AA_55AA;
    req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h2000;
    #1;
    step();
    req_valid = 1'b0; resetn = 1'b0;
    #1;
    chk("rst_wait.ready_low", 64'(o_req_ready), 64'h0);
    step();
    chk("rst_wait.valid", 64'(o_valid), 64'h0);
    chk("rst_wait.data", o_data, 64'h0);
    chk("rst_wait.exc", 64'(o_exc), 64'h0);
    chk("rst_wait.badvaddr", 64'(o_bad), 64'h0);
    resetn = 1'b1;
    #1;
    chk("rst_wait.ready", 64'(o_req_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_wait.no_valid", 64'(o_valid), 64'h0);
    end

    // 64-bit, RD_LAT=2
    sel = 2;
    do_reset();
    rdata = 64'h8000_0001_DEAD_BEEF;
    load_chk("lwu_4",  3'b101, 32'h0004, 2, 0, 64'h0000_0000_8000_0001);
    load_chk("lw_4",   3'b100, 32'h0004, 2, 0, 64'hFFFF_FFFF_8000_0001);
    load_chk("ld_8",   3'b110, 32'h0008, 2, 0, 64'h8000_0001_DEAD_BEEF);
    load_chk("lb_7",   3'b000, 32'h0007, 2, 0, 64'hFFFF_FFFF_FFFF_FF80);
    load_chk("lhu_2",  3'b011, 32'h0002, 2, 1, 64'h0000_0000_0000_DEAD);
    err_chk("ld_c",    3'b110, 32'h000C, 2'b01);
    err_chk("op7_64",  3'b111, 32'h0008, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential load-path unit between the MEM stage and the data SRAM.
- Accepts one load request at a time through a valid/ready handshake and issues an aligned SRAM read.
- Waits a parametrised read latency, then byte-selects and sign- or zero-extends the returned data.
- Presents the result to writeback through a valid/ready handshake.
- Generalises the writeback-side load formatter: parametrised bus width (32/64), 64-bit ops, address-error and illegal-op detection, backpressure, and flush.

Parameters:
- DATA_W, 32, SRAM data bus and result width; legal values 32 or 64.
- RD_LAT, 1, SRAM read latency in cycles from mem_en to valid mem_rdata; legal 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; cancels a pending or held load.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  load type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 LWU, 110 LD, 111 reserved.
- req_addr  in  32  byte virtual address.
- mem_en  out  1  SRAM read strobe (combinational).
- mem_addr  out  32  req_addr with low log2(DATA_W/8) bits cleared (combinational).
- mem_rdata  in  DATA_W  SRAM read data, little-endian lanes.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts the result.
- resp_data  out  DATA_W  aligned, extended load result.
- resp_exc  out  2  00 none, 01 AdEL, 10 illegal op.
- resp_badvaddr  out  32  req_addr of the load.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-low on resetn.
- Reset values: state IDLE, lat counter 0, resp_valid 0, resp_data 0, resp_exc 00, resp_badvaddr 0. req_ready is 0 while resetn is low, so mem_en is 0.
- States:
  - IDLE: no load in flight.
  - WAIT: counting SRAM latency.
  - DRAIN: flushed load still in flight in the SRAM.
  - RESP: holding a result.
- req_ready = (state==IDLE) && !flush. A request is accepted when req_valid && req_ready.
- Size per op:
  - LB/LBU: 1 byte.
  - LH/LHU: 2 bytes.
  - LW/LWU: 4 bytes.
  - LD: 8 bytes.
- Illegal op: 111 always; 101 and 110 when DATA_W==32.
- Misaligned: addr mod size != 0.
- Legal, aligned request:
  - mem_en=1 in the accept cycle.
  - Capture op, addr, and lane = addr[log2(DATA_W/8)-1:0].
  - Go to WAIT with counter = RD_LAT.
- Illegal or misaligned request:
  - mem_en=0.
  - Go directly to RESP next cycle with resp_data=0, resp_badvaddr=addr, and resp_exc=10 (illegal) or 01 (misaligned).
  - Illegal takes priority over misaligned.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, sample mem_rdata and go to RESP.
  - resp_valid rises RD_LAT+1 cycles after the accept edge.
- Data formatting:
  - field = mem_rdata >> (8*lane), truncated to size.
  - LB/LH/LW: sign-extend to DATA_W.
  - LBU/LHU/LWU: zero-extend to DATA_W.
  - LD: field unchanged.
  - resp_exc=00.
- RESP:
  - Outputs are held stable while resp_valid && !resp_ready.
  - On resp_ready: resp_valid drops and the state goes to IDLE.
  - No new request is accepted in the same cycle; one load is in flight at a time.
- Flush:
  - IDLE: the request is blocked (req_ready=0).
  - WAIT: go to DRAIN. Keep counting; the returned data is discarded, no response is issued, and the state goes to IDLE when the count completes (SRAM returns are never orphaned).
  - DRAIN: flush has no further effect.
  - RESP: resp_valid clears next cycle and the state goes to IDLE.
  - Flush together with resp_ready in RESP: same result (IDLE); the transfer is considered not taken.
- Reset mid-operation: returns to IDLE immediately. The in-flight SRAM datum is ignored; the SRAM has no cancel.
- resp_data is 0 whenever resp_valid=0.

Test Plan:
- DATA_W=32, RD_LAT=1: LB at 0x1003, mem_rdata=0x80112233 → resp_data=0xFFFFFF80 with resp_valid 2 cycles after accept; LBU same → 0x00000080; LH at 0x1002 → 0xFFFF8011.
- LH at 0x1001 → mem_en never asserted, resp_exc=01, resp_badvaddr=0x00001001, resp_data=0 one cycle after accept. req_op=111 → resp_exc=10.
- RD_LAT=3: LW at 0x2000, resp_ready held low 4 cycles → resp_valid and resp_data=mem_rdata held stable, req_ready=0 throughout; IDLE with req_ready=1 the cycle after resp_ready.
- RD_LAT=3: flush 1 cycle after accept → no resp_valid, req_ready stays 0 until the 3-cycle count drains, then 1; a following LW returns its own data, not the stale data.
- DATA_W=64, RD_LAT=2: LWU at 0x4 with mem_rdata=0x80000001_DEADBEEF → 0x00000000_80000001; LD at 0x8 → full word; LD at 0xC → AdEL. DATA_W=32 with LD → resp_exc=10.
- resetn low for 1 cycle during WAIT → all outputs at reset values next cycle, req_ready=1 after release, no spurious resp_valid.
